gcd_core: RTL and testbench

GCD_CORE -- requirements
Module: gcd_core

---
 rtl/gcd_core_if.sv | 23 ++
 rtl/gcd_core.sv | 126 ++++++++++++
 tb/tb_gcd_core.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_core_if.sv
// Operand/result handshake bundle for gcd_core: one valid/ready pair in, one out.
// master = requester driving operands, slave = the core.
interface gcd_core_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_gcd
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_gcd
    );
endinterface

// File: rtl/gcd_core.sv
// Subtractive GCD engine: IDLE -> CALC (one subtract per cycle) -> DONE.
// Define GCD_ZERO_ERR_EN to flag zero operands on err instead of computing gcd(a,0)=a.
module gcd_core #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    gcd_core_if.slave  bus,
    output logic       busy
`ifdef GCD_ZERO_ERR_EN
    ,
    output logic       err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    logic             calc_done;
    logic [WIDTH-1:0] calc_res;
`ifdef GCD_ZERO_ERR_EN
    logic             err_r;
    logic             calc_err;
`endif

    // Termination test for the current A/B pair; when not done the
    // sequential block subtracts the smaller operand from the larger.
    always_comb begin
        calc_done = 1'b1;
        calc_res  = a;
`ifdef GCD_ZERO_ERR_EN
        calc_err  = 1'b0;
        if (a == '0 || b == '0) begin
            calc_res = '0;
            calc_err = 1'b1;
        end else
`endif
        if (b == '0)
            calc_res = a;
        else if (a == '0)
            calc_res = b;
        else if (a == b)
            calc_res = a;
        else
            calc_done = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            a           <= '0;
            b           <= '0;
            result      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef GCD_ZERO_ERR_EN
            err_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a          <= bus.in_a;
                        b          <= bus.in_b;
                        state      <= CALC;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                CALC: begin
                    if (calc_done) begin
                        result      <= calc_res;
                        state       <= DONE;
                        out_valid_r <= 1'b1;
`ifdef GCD_ZERO_ERR_EN
                        err_r       <= calc_err;
`endif
                    end else if (a > b) begin
                        a <= a - b;
                    end else begin
                        b <= b - a;
                    end
                end
                DONE: begin
                    // Return to IDLE only; the next accept needs its own cycle.
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
`ifdef GCD_ZERO_ERR_EN
                        err_r       <= 1'b0;
`endif
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_gcd   = result;
    assign busy          = busy_r;
`ifdef GCD_ZERO_ERR_EN
    assign err           = err_r;
`endif

endmodule

// File: tb/tb_gcd_core.sv
// Directed bench for gcd_core: latency, backpressure, abort-by-reset, ignored input, zero operands.
module tb_gcd_core;
    localparam int W      = 32;
    localparam int BUDGET = 2000;

    logic clk;
    logic rst;
    logic busy;
`ifdef GCD_ZERO_ERR_EN
    logic err;
`endif

    gcd_core_if #(.WIDTH(W)) bus ();

    gcd_core #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
`ifdef GCD_ZERO_ERR_EN
        ,
        .err  (err)
`endif
    );

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < BUDGET) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        tick(); tick();
        checks++;
        if (bus.out_gcd !== '0) begin errors++; $display("FAIL reset_gcd: got %0d expected 0", bus.out_gcd); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
`ifdef GCD_ZERO_ERR_EN
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
`endif
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic test_12_8();
        int cyc;
        accept(32'd12, 32'd8);
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL g12_8_busy: got in_ready=%b busy=%b expected 0/1", bus.in_ready, busy);
        end
        wait_valid(cyc);
        checks++;
        if (cyc != 3) begin errors++; $display("FAIL g12_8_latency: got %0d expected 3", cyc); end
        checks++;
        if (bus.out_gcd !== 32'd4) begin errors++; $display("FAIL g12_8_gcd: got %0d expected 4", bus.out_gcd); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL g12_8_release: got valid=%b ready=%b busy=%b expected 0/1/0",
                               bus.out_valid, bus.in_ready, busy);
        end
    endtask

    task automatic test_17_5();
        int cyc;
        accept(32'd17, 32'd5);
        wait_valid(cyc);
        checks++;
        if (cyc != 7) begin errors++; $display("FAIL g17_5_latency: got %0d expected 7", cyc); end
        checks++;
        if (bus.out_gcd !== 32'd1) begin errors++; $display("FAIL g17_5_gcd: got %0d expected 1", bus.out_gcd); end
        tick();
    endtask

    task automatic test_msb();
        int cyc;
        accept(32'h8000_0000, 32'h4000_0000);
        wait_valid(cyc);
        checks++;
        if (cyc != 2 || bus.out_gcd !== 32'h4000_0000) begin
            errors++; $display("FAIL msb_pair: got lat=%0d gcd=%h expected 2/40000000", cyc, bus.out_gcd);
        end
        tick();
        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(cyc);
        checks++;
        if (cyc != 1 || bus.out_gcd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL max_equal: got lat=%0d gcd=%h expected 1/ffffffff", cyc, bus.out_gcd);
        end
        tick();
    endtask

    task automatic test_zero();
        int cyc;
        logic [W-1:0] za [3];
        logic [W-1:0] zb [3];
        logic [W-1:0] zexp [3];
        za = '{32'd0, 32'd7, 32'd0};
        zb = '{32'd9, 32'd0, 32'd0};
        zexp = '{32'd9, 32'd7, 32'd0};
        for (int i = 0; i < 3; i++) begin
            accept(za[i], zb[i]);
            wait_valid(cyc);
            checks++;
            if (cyc != 1) begin errors++; $display("FAIL zero_latency[%0d]: got %0d expected 1", i, cyc); end
`ifdef GCD_ZERO_ERR_EN
            checks++;
            if (bus.out_gcd !== '0 || err !== 1'b1) begin
                errors++; $display("FAIL zero_err[%0d]: got gcd=%0d err=%b expected 0/1", i, bus.out_gcd, err);
            end
`else
            checks++;
            if (bus.out_gcd !== zexp[i]) begin
                errors++; $display("FAIL zero_gcd[%0d]: got %0d expected %0d", i, bus.out_gcd, zexp[i]);
            end
`endif
            tick();
`ifdef GCD_ZERO_ERR_EN
            checks++;
            if (err !== 1'b0) begin errors++; $display("FAIL zero_err_clear[%0d]: got %b expected 0", i, err); end
`endif
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit bad;
        bus.out_ready = 1'b0;
        accept(32'd20, 32'd20);
        wait_valid(cyc);
        checks++;
        if (cyc != 1) begin errors++; $display("FAIL bp_latency: got %0d expected 1", cyc); end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_gcd !== 32'd20 || bus.in_ready !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad || bus.out_valid !== 1'b1 || bus.out_gcd !== 32'd20) begin
            errors++; $display("FAIL bp_hold: got valid=%b gcd=%0d expected 1/20 held", bus.out_valid, bus.out_gcd);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_abort();
        int cyc;
        bit seen;
        accept(32'd1000, 32'd3);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.out_valid === 1'b1) seen = 1'b1;
            tick();
        end
        rst = 1'b0;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_gcd !== '0) begin
            errors++; $display("FAIL abort_async: got valid=%b busy=%b ready=%b gcd=%0d expected 0/0/1/0",
                               bus.out_valid, busy, bus.in_ready, bus.out_gcd);
        end
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid === 1'b1) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen || busy !== 1'b0) begin
            errors++; $display("FAIL abort_no_result: got seen=%b busy=%b expected 0/0", seen, busy);
        end
        accept(32'd9, 32'd6);
        wait_valid(cyc);
        checks++;
        if (cyc != 3 || bus.out_gcd !== 32'd3) begin
            errors++; $display("FAIL abort_next_job: got lat=%0d gcd=%0d expected 3/3", cyc, bus.out_gcd);
        end
        tick();
    endtask

    task automatic test_ignore_input();
        int cyc;
        bit bad;
        accept(32'd12, 32'd8);
        bus.in_a     = 32'd8;
        bus.in_b     = 32'd4;
        bus.in_valid = 1'b1;
        bad = 1'b0;
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < BUDGET) begin
            if (bus.in_ready !== 1'b0) bad = 1'b1;
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad || bus.in_ready !== 1'b0) begin errors++; $display("FAIL ignore_in_ready: got ready high expected 0"); end
        checks++;
        if (cyc != 3 || bus.out_gcd !== 32'd4) begin
            errors++; $display("FAIL ignore_result: got lat=%0d gcd=%0d expected 3/4", cyc, bus.out_gcd);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        accept(32'd6, 32'd4);
        wait_valid(cyc);
        checks++;
        if (cyc != 3 || bus.out_gcd !== 32'd2) begin
            errors++; $display("FAIL b2b_first: got lat=%0d gcd=%0d expected 3/2", cyc, bus.out_gcd);
        end
        bus.in_a     = 32'd15;
        bus.in_b     = 32'd10;
        bus.in_valid = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle_gap: got ready=%b busy=%b expected 1/0", bus.in_ready, busy);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: got ready=%b busy=%b expected 0/1", bus.in_ready, busy);
        end
        wait_valid(cyc);
        checks++;
        if (cyc != 3 || bus.out_gcd !== 32'd5) begin
            errors++; $display("FAIL b2b_second: got lat=%0d gcd=%0d expected 3/5", cyc, bus.out_gcd);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_12_8();
        test_17_5();
        test_msb();
        test_zero();
        test_backpressure();
        test_abort();
        test_ignore_input();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
